// File: rtl/regfile_wb_arbiter.sv
// Write-back controller for the general purpose register file.
// Two requesters (A: ALU result, B: load result) share the single write
// port under round-robin arbitration. A per-register pending-write
// scoreboard lets decode detect read-after-write hazards.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                a_req,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  output logic                a_gnt,
  input  logic                b_req,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  output logic                b_gnt,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_addr,
  input  logic [ADDR_W-1:0]   chk_addr1,
  input  logic [ADDR_W-1:0]   chk_addr2,
  output logic                hazard,
  output logic [NUM_REGS-1:0] pend,
  output logic                RegWr,
  output logic [ADDR_W-1:0]   Waddr,
  output logic [DATA_W-1:0]   Writedata,
  output logic                bad_addr
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0]   LIM = (ADDR_W+1)'(NUM_REGS);
  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

  // Pointer: 0 = A wins the next contention, 1 = B wins it.
  logic r_ptr_b;

  logic                w_a_elig;
  logic                w_b_elig;
  logic                w_a_win;
  logic                w_b_win;
  logic                w_any;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_data;
  logic                w_win_legal;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_pend_nxt;

  function automatic logic f_legal(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < LIM);
  endfunction

  // A grant that is still visible masks the requester, since it only
  // drops its request on the edge after seeing the grant.
  assign w_a_elig = a_req & ~a_gnt;
  assign w_b_elig = b_req & ~b_gnt;

  assign w_a_win = w_a_elig & (~w_b_elig | ~r_ptr_b);
  assign w_b_win = w_b_elig & (~w_a_elig |  r_ptr_b);
  assign w_any   = w_a_win | w_b_win;

  assign w_win_addr  = w_b_win ? b_addr : a_addr;
  assign w_win_data  = w_b_win ? b_data : a_data;
  assign w_win_legal = f_legal(w_win_addr);

  // Set is applied after clear so a newer producer stays outstanding.
  assign w_clr_mask = (w_any & w_win_legal) ? (ONE << w_win_addr[IDX_W-1:0]) : '0;
  assign w_set_mask = (issue_valid & f_legal(issue_addr)) ?
                      (ONE << issue_addr[IDX_W-1:0]) : '0;
  assign w_pend_nxt = (pend & ~w_clr_mask) | w_set_mask;

  // Hazard lookup is combinational; illegal check addresses never hit.
  assign hazard = (f_legal(chk_addr1) & pend[chk_addr1[IDX_W-1:0]]) |
                  (f_legal(chk_addr2) & pend[chk_addr2[IDX_W-1:0]]);

  // Arbitration result, write port and scoreboard registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_ptr_b   <= 1'b0;
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      RegWr     <= 1'b0;
      bad_addr  <= 1'b0;
      Waddr     <= '0;
      Writedata <= '0;
      pend      <= '0;
    end else begin
      a_gnt    <= w_a_win;
      b_gnt    <= w_b_win;
      RegWr    <= w_any & w_win_legal;
      bad_addr <= w_any & ~w_win_legal;
      pend     <= w_pend_nxt;
      if (w_any) begin
        Waddr     <= w_win_addr;
        Writedata <= w_win_data;
      end else begin
        Waddr     <= '0;
        Writedata <= '0;
      end
      if (w_a_win) begin
        r_ptr_b <= 1'b1;
      end else if (w_b_win) begin
        r_ptr_b <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand-written
// contention and mid-write reset sequences, then randomized traffic
// against a behavioural model of arbitration, scoreboard and register file.
module tb_regfile_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        a_req, b_req, issue_valid;
  logic [4:0]  a_addr, b_addr, issue_addr, chk_addr1, chk_addr2;
  logic [31:0] a_data, b_data;
  logic        a_gnt, b_gnt, hazard, RegWr, bad_addr;
  logic [15:0] pend;
  logic [4:0]  Waddr;
  logic [31:0] Writedata;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .hazard(hazard), .pend(pend),
    .RegWr(RegWr), .Waddr(Waddr), .Writedata(Writedata), .bad_addr(bad_addr)
  );

  always #5 CLK = ~CLK;

  // Register file written by the DUT's write port on the falling edge.
  logic [31:0] rf [16] = '{default: 32'h0};
  always @(negedge CLK) begin
    if (RegWr && Waddr < 5'd16) rf[Waddr[3:0]] <= Writedata;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic a_req; logic [4:0] a_addr; logic [31:0] a_data;
    logic b_req; logic [4:0] b_addr; logic [31:0] b_data;
    logic iv; logic [4:0] ia; logic [4:0] c1; logic [4:0] c2;
    logic e_ag; logic e_bg; logic e_wr; logic e_bad;
    logic [4:0] e_wa; logic [31:0] e_wd; logic [15:0] e_pend; logic e_hz;
  } vec_t;

  vec_t vt [13];

  function automatic vec_t mk(
    input logic ar, input logic [4:0] aa, input logic [31:0] ad,
    input logic br, input logic [4:0] ba, input logic [31:0] bd,
    input logic iv, input logic [4:0] ia, input logic [4:0] c1, input logic [4:0] c2,
    input logic ag, input logic bg, input logic wr, input logic bad,
    input logic [4:0] wa, input logic [31:0] wd, input logic [15:0] pd, input logic hz);
    vec_t v;
    v.a_req = ar; v.a_addr = aa; v.a_data = ad;
    v.b_req = br; v.b_addr = ba; v.b_data = bd;
    v.iv = iv; v.ia = ia; v.c1 = c1; v.c2 = c2;
    v.e_ag = ag; v.e_bg = bg; v.e_wr = wr; v.e_bad = bad;
    v.e_wa = wa; v.e_wd = wd; v.e_pend = pd; v.e_hz = hz;
    return v;
  endfunction

  // Behavioural model state
  logic        m_ag, m_bg, m_wr, m_bad;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          m_tie_winner;   // 1 = A, 2 = B wins the next contention
  bit          m_pend [16];
  logic [31:0] m_mem [16];

  function automatic logic [15:0] model_pend_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic model_hazard(input logic [4:0] c1, input logic [4:0] c2);
    logic h;
    h = 1'b0;
    if (c1 < 5'd16 && m_pend[c1[3:0]]) h = 1'b1;
    if (c2 < 5'd16 && m_pend[c2[3:0]]) h = 1'b1;
    return h;
  endfunction

  task automatic model_reset();
    m_ag = 0; m_bg = 0; m_wr = 0; m_bad = 0; m_wa = '0; m_wd = '0;
    m_tie_winner = 1;
    for (int i = 0; i < 16; i++) m_pend[i] = 0;
  endtask

  // Outcome of the coming posedge given the current inputs.
  task automatic model_step();
    bit ea, eb;
    int win;
    logic [4:0] wa;
    logic [31:0] wd;
    ea = a_req && !m_ag;
    eb = b_req && !m_bg;
    if (ea && eb)  win = m_tie_winner;
    else if (ea)   win = 1;
    else if (eb)   win = 2;
    else           win = 0;
    wa = (win == 2) ? b_addr : a_addr;
    wd = (win == 2) ? b_data : a_data;
    m_ag  = (win == 1);
    m_bg  = (win == 2);
    m_wr  = (win != 0) && (wa < 5'd16);
    m_bad = (win != 0) && (wa >= 5'd16);
    m_wa  = (win != 0) ? wa : 5'd0;
    m_wd  = (win != 0) ? wd : 32'd0;
    if (win != 0) m_tie_winner = 3 - win;
    if (m_wr) begin
      m_pend[wa[3:0]] = 0;
      m_mem[wa[3:0]]  = wd;
    end
    if (issue_valid && issue_addr < 5'd16) m_pend[issue_addr[3:0]] = 1;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_addr = '0; a_data = '0;
    b_req = 0; b_addr = '0; b_data = '0;
    issue_valid = 0; issue_addr = '0; chk_addr1 = '0; chk_addr2 = '0;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    check("rst_a_gnt", 32'(a_gnt), 32'd0);
    check("rst_b_gnt", 32'(b_gnt), 32'd0);
    check("rst_RegWr", 32'(RegWr), 32'd0);
    check("rst_bad_addr", 32'(bad_addr), 32'd0);
    check("rst_pend", 32'(pend), 32'd0);
    check("rst_Waddr", 32'(Waddr), 32'd0);
    check("rst_Writedata", Writedata, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b1;
  endtask

  task automatic drive(input vec_t v);
    a_req = v.a_req; a_addr = v.a_addr; a_data = v.a_data;
    b_req = v.b_req; b_addr = v.b_addr; b_data = v.b_data;
    issue_valid = v.iv; issue_addr = v.ia; chk_addr1 = v.c1; chk_addr2 = v.c2;
  endtask

  logic [31:0] saved;

  initial begin
    RESET = 1'b0;
    idle_inputs();
    do_reset();

    // ---------------- Directed vector table ----------------
    //          a_req a_addr a_data   b_req b_addr b_data  iv ia c1 c2 | ag bg wr bad wa wd pend hz
    vt[0]  = mk(1'b1,5'd3, 32'hDEADBEEF,1'b0,5'd0,32'd0, 1'b0,5'd0, 5'd0, 5'd0,
                1'b1,1'b0,1'b1,1'b0,5'd3,32'hDEADBEEF,16'h0000,1'b0);
    vt[1]  = mk(1'b0,5'd3, 32'hDEADBEEF,1'b0,5'd0,32'd0, 1'b0,5'd0, 5'd0, 5'd0,
                1'b0,1'b0,1'b0,1'b0,5'd0,32'd0,16'h0000,1'b0);
    vt[2]  = mk(1'b0,5'd0, 32'd0,1'b0,5'd0,32'd0, 1'b1,5'd5, 5'd5, 5'd0,
                1'b0,1'b0,1'b0,1'b0,5'd0,32'd0,16'h0020,1'b1);
    vt[3]  = mk(1'b0,5'd0, 32'd0,1'b0,5'd0,32'd0, 1'b0,5'd0, 5'd4, 5'd0,
                1'b0,1'b0,1'b0,1'b0,5'd0,32'd0,16'h0020,1'b0);
    vt[4]  = mk(1'b0,5'd0, 32'd0,1'b1,5'd5,32'h55, 1'b0,5'd0, 5'd5, 5'd0,
                1'b0,1'b1,1'b1,1'b0,5'd5,32'h55,16'h0000,1'b0);
    vt[5]  = mk(1'b1,5'd7, 32'h77,1'b0,5'd0,32'd0, 1'b1,5'd7, 5'd7, 5'd0,
                1'b1,1'b0,1'b1,1'b0,5'd7,32'h77,16'h0080,1'b1);
    vt[6]  = mk(1'b0,5'd0, 32'd0,1'b0,5'd0,32'd0, 1'b0,5'd0, 5'd7, 5'd0,
                1'b0,1'b0,1'b0,1'b0,5'd0,32'd0,16'h0080,1'b1);
    vt[7]  = mk(1'b1,5'd20,32'hAAAA,1'b0,5'd0,32'd0, 1'b1,5'd20, 5'd23, 5'd0,
                1'b1,1'b0,1'b0,1'b1,5'd20,32'hAAAA,16'h0080,1'b0);
    vt[8]  = mk(1'b0,5'd0, 32'd0,1'b0,5'd0,32'd0, 1'b0,5'd0, 5'd23, 5'd0,
                1'b0,1'b0,1'b0,1'b0,5'd0,32'd0,16'h0080,1'b0);
    vt[9]  = mk(1'b1,5'd1, 32'h11,1'b1,5'd2,32'h22, 1'b0,5'd0, 5'd0, 5'd7,
                1'b0,1'b1,1'b1,1'b0,5'd2,32'h22,16'h0080,1'b1);
    vt[10] = mk(1'b1,5'd1, 32'h11,1'b1,5'd2,32'h22, 1'b0,5'd0, 5'd0, 5'd7,
                1'b1,1'b0,1'b1,1'b0,5'd1,32'h11,16'h0080,1'b1);
    vt[11] = mk(1'b1,5'd1, 32'h11,1'b1,5'd2,32'h22, 1'b0,5'd0, 5'd0, 5'd7,
                1'b0,1'b1,1'b1,1'b0,5'd2,32'h22,16'h0080,1'b1);
    vt[12] = mk(1'b0,5'd0, 32'd0,1'b0,5'd0,32'd0, 1'b0,5'd0, 5'd0, 5'd7,
                1'b0,1'b0,1'b0,1'b0,5'd0,32'd0,16'h0080,1'b1);

    for (int i = 0; i < 13; i++) begin
      drive(vt[i]);
      @(posedge CLK); #1;
      check($sformatf("v%0d_a_gnt", i), 32'(a_gnt), 32'(vt[i].e_ag));
      check($sformatf("v%0d_b_gnt", i), 32'(b_gnt), 32'(vt[i].e_bg));
      check($sformatf("v%0d_RegWr", i), 32'(RegWr), 32'(vt[i].e_wr));
      check($sformatf("v%0d_bad_addr", i), 32'(bad_addr), 32'(vt[i].e_bad));
      check($sformatf("v%0d_Waddr", i), 32'(Waddr), 32'(vt[i].e_wa));
      check($sformatf("v%0d_Writedata", i), Writedata, vt[i].e_wd);
      check($sformatf("v%0d_pend", i), 32'(pend), 32'(vt[i].e_pend));
      check($sformatf("v%0d_hazard", i), 32'(hazard), 32'(vt[i].e_hz));
    end
    @(negedge CLK); #1;
    check("rf3_readback", rf[3], 32'hDEADBEEF);
    check("rf5_readback", rf[5], 32'h55);
    check("rf7_readback", rf[7], 32'h77);
    check("rf1_readback", rf[1], 32'h11);
    check("rf2_readback", rf[2], 32'h22);
    check("rf4_untouched_by_illegal", rf[4], 32'h0);

    // ---------------- Contention from reset ----------------
    do_reset();
    a_req = 1; a_addr = 5'd1; a_data = 32'd11;
    b_req = 1; b_addr = 5'd2; b_data = 32'd22;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK); #1;
      check($sformatf("alt%0d_a_gnt", k), 32'(a_gnt), 32'((k % 2) == 0));
      check($sformatf("alt%0d_b_gnt", k), 32'(b_gnt), 32'((k % 2) == 1));
      check($sformatf("alt%0d_RegWr", k), 32'(RegWr), 32'd1);
    end
    idle_inputs();
    @(posedge CLK); #1;

    // ---------------- Reset in the middle of a write ----------------
    saved = rf[9];
    issue_valid = 1; issue_addr = 5'd4;
    @(posedge CLK); #1;
    issue_valid = 0;
    a_req = 1; a_addr = 5'd9; a_data = 32'h99999999;
    @(posedge CLK); #1;
    check("mid_RegWr_before", 32'(RegWr), 32'd1);
    check("mid_pend_before", 32'(pend), 32'h10);
    #1;
    RESET = 1'b0;
    #1;
    check("mid_RegWr_dropped", 32'(RegWr), 32'd0);
    check("mid_a_gnt_dropped", 32'(a_gnt), 32'd0);
    check("mid_pend_cleared", 32'(pend), 32'd0);
    idle_inputs();
    @(negedge CLK); #1;
    check("mid_rf9_unchanged", rf[9], saved);
    @(posedge CLK); #1;
    RESET = 1'b1;
    model_reset();
    @(posedge CLK); #1;
    check("post_rst_pend", 32'(pend), 32'd0);
    check("post_rst_a_gnt", 32'(a_gnt), 32'd0);
    check("post_rst_b_gnt", 32'(b_gnt), 32'd0);

    // ---------------- Randomized traffic against model ----------------
    do_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = rf[i];
    for (int c = 0; c < 400; c++) begin
      if (!a_req || m_ag) begin
        a_req  = ($urandom_range(0, 2) != 0);
        a_addr = 5'($urandom_range(0, 19));
        a_data = $urandom;
      end
      if (!b_req || m_bg) begin
        b_req  = ($urandom_range(0, 2) != 0);
        b_addr = 5'($urandom_range(0, 19));
        b_data = $urandom;
      end
      issue_valid = ($urandom_range(0, 1) != 0);
      issue_addr  = 5'($urandom_range(0, 19));
      chk_addr1   = 5'($urandom_range(0, 31));
      chk_addr2   = 5'($urandom_range(0, 31));
      #1;
      check("rnd_hazard", 32'(hazard), 32'(model_hazard(chk_addr1, chk_addr2)));
      model_step();
      @(posedge CLK); #1;
      check("rnd_a_gnt", 32'(a_gnt), 32'(m_ag));
      check("rnd_b_gnt", 32'(b_gnt), 32'(m_bg));
      check("rnd_RegWr", 32'(RegWr), 32'(m_wr));
      check("rnd_bad_addr", 32'(bad_addr), 32'(m_bad));
      check("rnd_Waddr", 32'(Waddr), 32'(m_wa));
      check("rnd_Writedata", Writedata, m_wd);
      check("rnd_pend", 32'(pend), 32'(model_pend_vec()));
    end
    idle_inputs();
    @(negedge CLK); #1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("rnd_rf%0d", i), rf[i], m_mem[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back controller for the 16 x 32-bit general purpose register file.
- Shares the register file's single write port (RegWr/Waddr/Writedata, written on negedge CLK) between two requesters: A (ALU result) and B (load/memory result).
- Uses round-robin arbitration.
- Keeps a per-register pending-write scoreboard so decode can detect read-after-write hazards against in-flight results.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width (instruction field width)
NUM_REGS, 16, number of implemented registers; addresses >= NUM_REGS are illegal

Ports:
CLK  in  1  clock; all state updates on posedge CLK
RESET  in  1  asynchronous, active-low reset
a_req  in  1  requester A has a result to write; held until a_gnt seen
a_addr  in  ADDR_W  requester A destination register
a_data  in  DATA_W  requester A write data
a_gnt  out  1  registered; high for one cycle when A's request is consumed
b_req  in  1  requester B request (same rules as A)
b_addr  in  ADDR_W  requester B destination register
b_data  in  DATA_W  requester B write data
b_gnt  out  1  registered grant to B
issue_valid  in  1  decode issued an instruction that will write issue_addr
issue_addr  in  ADDR_W  destination register of the issued instruction
chk_addr1  in  ADDR_W  decode source register 1
chk_addr2  in  ADDR_W  decode source register 2
hazard  out  1  combinational: pend[chk_addr1] | pend[chk_addr2]; an illegal chk address contributes 0
pend  out  NUM_REGS  scoreboard: bit i = write to register i outstanding
RegWr  out  1  register file write enable
Waddr  out  ADDR_W  register file write address
Writedata  out  DATA_W  register file write data
bad_addr  out  1  one-cycle pulse: granted request targeted an illegal register

Behaviour:
Reset (RESET low, asynchronous):
- a_gnt, b_gnt, RegWr, bad_addr, pend = 0; Waddr = 0; Writedata = 0.
- Round-robin pointer = A (A wins the first contention).
- Reset mid-operation drops any in-flight write: RegWr is forced to 0 immediately, so no negedge write occurs.

Eligibility:
- A is eligible at a posedge if a_req=1 and a_gnt=0 (requester drops req on the edge after seeing gnt). The mask prevents a double grant.
- B: same rule with b_req/b_gnt.

Arbitration at each posedge:
- Neither eligible: all grant and write outputs return to 0.
- One eligible: that requester wins.
- Both eligible: the requester named by the pointer wins; pointer then moves to the loser. A single-requester grant sets the pointer to the other requester.
- Result: one requester gets at most one grant every 2 cycles; A and B can alternate back-to-back, giving one write per cycle.

Winner, legal address (addr < NUM_REGS), outputs for the following cycle:
- x_gnt = 1; RegWr = 1; Waddr = addr; Writedata = data.
- The register file commits at the negedge inside that cycle.
- Latency: request sampled at edge N, write committed at negedge between N and N+1.

Winner, illegal address:
- x_gnt = 1; RegWr = 0; bad_addr = 1 for one cycle; the request is consumed and discarded.
- Waddr/Writedata still load the winner's values; don't-care while RegWr = 0.

Outputs are registered and only change on posedge/reset, so they are stable at the negedge.

Scoreboard, per posedge:
- Set: issue_valid with legal issue_addr sets pend[issue_addr]. Illegal issue_addr is ignored.
- Clear: a legal grant at the same edge clears pend[winner addr].
- Set and clear on the same register at the same edge: set wins (a newer producer is outstanding).
- A write to a non-pending register is performed normally; pend is unchanged.

hazard is purely combinational from pend and the chk addresses; no added latency.

Test Plan:
- Reset then single write: a_req=1, a_addr=3, a_data=32'hDEADBEEF at edge 1 -> next cycle a_gnt=1, RegWr=1, Waddr=3, Writedata=DEADBEEF; read-back of reg 3 = DEADBEEF; A drops req -> RegWr=0 following cycle.
- Contention with held requests: A and B request continuously from reset (A addr 1/data 11, B addr 2/data 22) -> grants alternate A,B,A,B each cycle, never the same requester twice in a row; RegWr stays 1.
- Scoreboard: issue_valid with addr 5 -> pend[5]=1; hazard=1 with chk_addr1=5, hazard=0 with chk_addr1=4; B writes reg 5 -> pend[5]=0 the cycle b_gnt is high.
- Simultaneous set/clear: issue_valid addr 7 at the same edge as A's grant to addr 7 -> pend[7] stays 1; RegWr=1, Waddr=7.
- Illegal address: a_addr=5'd20 -> a_gnt=1, bad_addr=1 for one cycle, RegWr=0, pend unchanged, no register modified; issue_addr=20 sets no pend bit.
- Reset mid-operation: assert RESET low during the RegWr=1 cycle before the negedge -> RegWr falls immediately, target register unchanged; pend=0 and all grants=0 after release.
